// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2**WINDOW_BITS samples
// and returns the count on y via valid/ready. Define BITSTREAM_BIPOLAR_EN for y = 2*count - WINDOW.
module bitstream_decoder #(
    parameter int WINDOW_BITS = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        bit_in,
    output logic        busy,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] y
);

    localparam int WINDOW = 1 << WINDOW_BITS;
    localparam logic [WINDOW_BITS-1:0] CNT_LAST = WINDOW_BITS'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WINDOW_BITS:0]   acc, acc_nxt, sum;
    logic [WINDOW_BITS-1:0] cnt, cnt_nxt;
    logic [31:0]            y_nxt, result;
    logic                   busy_nxt, valid_nxt;

    // One extra accumulator bit so an all-ones window reaches WINDOW without wrapping.
    assign sum = acc + (WINDOW_BITS+1)'(bit_in);

`ifdef BITSTREAM_BIPOLAR_EN
    assign result = (32'(sum) << 1) - 32'(WINDOW);
`else
    assign result = 32'(sum);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            y     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        y_nxt     = y;
        valid_nxt = valid;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COUNT;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            COUNT: begin
                acc_nxt = sum;
                cnt_nxt = cnt + WINDOW_BITS'(1);
                if (cnt == CNT_LAST) begin
                    y_nxt     = result;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Accept and optionally chain straight into the next window.
                if (ready) begin
                    valid_nxt = 1'b0;
                    if (start) begin
                        state_nxt = COUNT;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
